// File: rtl/bfly_pair_demux_16_to_32.sv
`default_nettype none
// ============================================================================
// Module   : bfly_pair_demux_16_to_32
// Purpose  : Radix-2 butterfly front end. Pairs consecutive 16-lane complex
//            blocks A,B and registers lane-wise A+B and A-B with one bit of
//            growth. A two-phase mux_sel (add, then sub) lets a downstream
//            32-to-16 select re-serialise the results at one block per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bfly_pair_demux_16_to_32 #(
    parameter int IN_WIDTH        = 9,
    parameter int OUT_WIDTH       = 10,
    parameter int PAIRS_PER_FRAME = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        din_valid,
    input  logic                        din_sof,
    input  logic signed [IN_WIDTH-1:0]  din_R        [0:15],
    input  logic signed [IN_WIDTH-1:0]  din_Q        [0:15],
    output logic signed [OUT_WIDTH-1:0] dout_R_add00 [0:15],
    output logic signed [OUT_WIDTH-1:0] dout_Q_add00 [0:15],
    output logic signed [OUT_WIDTH-1:0] dout_R_sub00 [0:15],
    output logic signed [OUT_WIDTH-1:0] dout_Q_sub00 [0:15],
    output logic                        mux_sel,
    output logic                        dout_valid,
    output logic                        dout_last
);

    localparam int LANES = 16;
    localparam int CNT_W = (PAIRS_PER_FRAME > 1) ? $clog2(PAIRS_PER_FRAME) : 1;
    localparam int EXT_W = OUT_WIDTH - IN_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PAIRS_PER_FRAME - 1);

    typedef enum logic [0:0] {
        PAIR_EMPTY = 1'b0,
        PAIR_HALF  = 1'b1
    } pair_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_ADD  = 2'd1,
        OUT_SUB  = 2'd2
    } out_state_t;

    pair_state_t                 pair_state_q;
    out_state_t                  out_state_q;
    logic        [CNT_W-1:0]     pair_cnt_q;
    logic        [CNT_W-1:0]     pair_cnt_d;

    // Held A block waiting for its B partner
    logic signed [IN_WIDTH-1:0]  a_R_q   [0:LANES-1];
    logic signed [IN_WIDTH-1:0]  a_Q_q   [0:LANES-1];

    // Butterfly results: next-state from the held A and the incoming B
    logic signed [OUT_WIDTH-1:0] add_R_d [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] add_Q_d [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] sub_R_d [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] sub_Q_d [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] add_R_q [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] add_Q_q [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] sub_R_q [0:LANES-1];
    logic signed [OUT_WIDTH-1:0] sub_Q_q [0:LANES-1];

    logic                        mux_sel_q;
    logic                        dout_valid_q;
    logic                        dout_last_q;
    // Remembers that the pair just loaded closes the frame, so the SUB
    // phase one cycle later can flag it.
    logic                        last_pend_q;

    logic                        a_load;
    logic                        b_load;
    logic                        realign;

    // ------------------------------------------------------------------------
    // Input qualification. A start-of-frame block is always an A: in EMPTY it
    // is an ordinary capture, in HALF it replaces the stale held A.
    // ------------------------------------------------------------------------
    assign realign = din_valid & din_sof;
    assign a_load  = din_valid & ((pair_state_q == PAIR_EMPTY) | din_sof);
    assign b_load  = din_valid & (pair_state_q == PAIR_HALF) & ~din_sof;

    // Pair counter next state: frame start clears, each completed pair counts
    always_comb begin
        pair_cnt_d = pair_cnt_q;
        if (realign) begin
            pair_cnt_d = '0;
        end else if (b_load) begin
            pair_cnt_d = pair_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Per-lane butterfly: sign-extend both operands to the output width first
    // so the sum/difference is exact over the full input range.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [OUT_WIDTH-1:0] a_r_ext;
        logic signed [OUT_WIDTH-1:0] a_q_ext;
        logic signed [OUT_WIDTH-1:0] b_r_ext;
        logic signed [OUT_WIDTH-1:0] b_q_ext;

        assign a_r_ext = {{EXT_W{a_R_q[g][IN_WIDTH-1]}}, a_R_q[g]};
        assign a_q_ext = {{EXT_W{a_Q_q[g][IN_WIDTH-1]}}, a_Q_q[g]};
        assign b_r_ext = {{EXT_W{din_R[g][IN_WIDTH-1]}}, din_R[g]};
        assign b_q_ext = {{EXT_W{din_Q[g][IN_WIDTH-1]}}, din_Q[g]};

        assign add_R_d[g] = a_r_ext + b_r_ext;
        assign add_Q_d[g] = a_q_ext + b_q_ext;
        assign sub_R_d[g] = a_r_ext - b_r_ext;
        assign sub_Q_d[g] = a_q_ext - b_q_ext;
    end

    // Pair FSM: tracks whether an A is held, captures A blocks, counts pairs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_state_q <= PAIR_EMPTY;
            pair_cnt_q   <= '0;
            for (int i = 0; i < LANES; i++) begin
                a_R_q[i] <= '0;
                a_Q_q[i] <= '0;
            end
        end else begin
            pair_cnt_q <= pair_cnt_d;
            if (a_load) begin
                for (int i = 0; i < LANES; i++) begin
                    a_R_q[i] <= din_R[i];
                    a_Q_q[i] <= din_Q[i];
                end
            end
            if (din_valid) begin
                case (pair_state_q)
                    PAIR_EMPTY: pair_state_q <= PAIR_HALF;
                    PAIR_HALF:  pair_state_q <= din_sof ? PAIR_HALF : PAIR_EMPTY;
                    default:    pair_state_q <= PAIR_EMPTY;
                endcase
            end
        end
    end

    // Result registers: load only when a B completes a pair, else hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                add_R_q[i] <= '0;
                add_Q_q[i] <= '0;
                sub_R_q[i] <= '0;
                sub_Q_q[i] <= '0;
            end
        end else if (b_load) begin
            for (int i = 0; i < LANES; i++) begin
                add_R_q[i] <= add_R_d[i];
                add_Q_q[i] <= add_Q_d[i];
                sub_R_q[i] <= sub_R_d[i];
                sub_Q_q[i] <= sub_Q_d[i];
            end
        end
    end

    // Output FSM: one ADD cycle then one SUB cycle per loaded pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_state_q  <= OUT_IDLE;
            mux_sel_q    <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            last_pend_q  <= 1'b0;
        end else if (b_load) begin
            // A fresh pair always starts in the add phase; the 2-cycle
            // minimum B spacing guarantees the previous SUB has completed.
            out_state_q  <= OUT_ADD;
            mux_sel_q    <= 1'b0;
            dout_valid_q <= 1'b1;
            dout_last_q  <= 1'b0;
            last_pend_q  <= (pair_cnt_q == LAST_CNT);
        end else begin
            case (out_state_q)
                OUT_ADD: begin
                    out_state_q  <= OUT_SUB;
                    mux_sel_q    <= 1'b1;
                    dout_valid_q <= 1'b1;
                    dout_last_q  <= last_pend_q;
                end
                default: begin
                    out_state_q  <= OUT_IDLE;
                    mux_sel_q    <= 1'b0;
                    dout_valid_q <= 1'b0;
                    dout_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout_R_add00 = add_R_q;
    assign dout_Q_add00 = add_Q_q;
    assign dout_R_sub00 = sub_R_q;
    assign dout_Q_sub00 = sub_Q_q;
    assign mux_sel      = mux_sel_q;
    assign dout_valid   = dout_valid_q;
    assign dout_last    = dout_last_q;

endmodule
`default_nettype wire

// File: tb/tb_bfly_pair_demux_16_to_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_bfly_pair_demux_16_to_32
// Purpose  : Self-checking bench for bfly_pair_demux_16_to_32: table-driven
//            butterfly vectors plus hand-written reset, streaming, gap and
//            frame-realign sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bfly_pair_demux_16_to_32;

    typedef logic [15:0][8:0] blk_t;
    typedef logic [15:0][9:0] res_t;

    typedef struct packed {
        blk_t a_r;
        blk_t a_q;
        blk_t b_r;
        blk_t b_q;
        res_t add_r;
        res_t add_q;
        res_t sub_r;
        res_t sub_q;
    } vec_t;

    logic              clk;
    logic              rst;
    logic              din_valid;
    logic              din_sof;
    logic signed [8:0] din_R        [0:15];
    logic signed [8:0] din_Q        [0:15];
    logic signed [9:0] dout_R_add00 [0:15];
    logic signed [9:0] dout_Q_add00 [0:15];
    logic signed [9:0] dout_R_sub00 [0:15];
    logic signed [9:0] dout_Q_sub00 [0:15];
    logic              mux_sel;
    logic              dout_valid;
    logic              dout_last;

    int n_checks;
    int n_errors;

    vec_t vecs [5];

    bfly_pair_demux_16_to_32 #(
        .IN_WIDTH        (9),
        .OUT_WIDTH       (10),
        .PAIRS_PER_FRAME (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .din_valid    (din_valid),
        .din_sof      (din_sof),
        .din_R        (din_R),
        .din_Q        (din_Q),
        .dout_R_add00 (dout_R_add00),
        .dout_Q_add00 (dout_Q_add00),
        .dout_R_sub00 (dout_R_sub00),
        .dout_Q_sub00 (dout_Q_sub00),
        .mux_sel      (mux_sel),
        .dout_valid   (dout_valid),
        .dout_last    (dout_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic s, input blk_t r, input blk_t q);
        din_valid = v;
        din_sof   = s;
        for (int i = 0; i < 16; i++) begin
            din_R[i] = r[i];
            din_Q[i] = q[i];
        end
    endtask

    task automatic check_bit(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // which: 0 add R, 1 add Q, 2 sub R, 3 sub Q
    task automatic check_arr(input string nm, input int which, input res_t exp);
        logic [9:0] act;
        int         bad;
        logic [9:0] bad_act;
        bad     = -1;
        bad_act = '0;
        for (int i = 0; i < 16; i++) begin
            case (which)
                0:       act = dout_R_add00[i];
                1:       act = dout_Q_add00[i];
                2:       act = dout_R_sub00[i];
                default: act = dout_Q_sub00[i];
            endcase
            if (act !== exp[i] && bad < 0) begin
                bad     = i;
                bad_act = act;
            end
        end
        n_checks++;
        if (bad >= 0) begin
            n_errors++;
            $display("FAIL %s lane %0d: got %0d expected %0d (t=%0t)", nm, bad,
                     $signed(bad_act), $signed(exp[bad]), $time);
        end
    endtask

    task automatic check_dp(input string nm, input res_t ar, input res_t aq,
                            input res_t sr, input res_t sq);
        check_arr({nm, ".addR"}, 0, ar);
        check_arr({nm, ".addQ"}, 1, aq);
        check_arr({nm, ".subR"}, 2, sr);
        check_arr({nm, ".subQ"}, 3, sq);
    endtask

    task automatic check_ctl(input string nm, input logic v, input logic m, input logic l);
        check_bit({nm, ".valid"}, dout_valid, v);
        check_bit({nm, ".mux_sel"}, mux_sel, m);
        check_bit({nm, ".last"}, dout_last, l);
    endtask

    // One isolated pair: A, B, then idle; checks ADD, SUB and IDLE phases
    task automatic run_vec(input string nm, input vec_t v);
        set_in(1'b1, 1'b0, v.a_r, v.a_q);
        tick();
        set_in(1'b1, 1'b0, v.b_r, v.b_q);
        tick();
        set_in(1'b0, 1'b0, '0, '0);
        check_ctl({nm, ".add_ph"}, 1'b1, 1'b0, 1'b0);
        check_dp({nm, ".add_ph"}, v.add_r, v.add_q, v.sub_r, v.sub_q);
        tick();
        check_ctl({nm, ".sub_ph"}, 1'b1, 1'b1, 1'b0);
        check_dp({nm, ".sub_ph"}, v.add_r, v.add_q, v.sub_r, v.sub_q);
        tick();
        check_ctl({nm, ".idle"}, 1'b0, 1'b0, 1'b0);
    endtask

    // 32 back-to-back blocks (first flagged sof); block k lane i: R=k+i, Q=k-i.
    // Pair p = blocks (2p, 2p+1): add R=4p+1+2i, add Q=4p+1-2i, sub R=Q=-1.
    task automatic stream(input string nm);
        blk_t r;
        blk_t q;
        res_t er;
        res_t eq;
        res_t em1;
        int   lasts;
        int   p;
        lasts = 0;
        for (int i = 0; i < 16; i++) em1[i] = 10'(-1);
        for (int k = 0; k < 32; k++) begin
            for (int i = 0; i < 16; i++) begin
                r[i] = 9'(k + i);
                q[i] = 9'(k - i);
            end
            set_in(1'b1, (k == 0), r, q);
            tick();
            if (dout_last === 1'b1) lasts++;
            if (k == 0) begin
                check_bit({nm, ".first.valid"}, dout_valid, 1'b0);
            end else if (k % 2 == 1) begin
                p = (k - 1) / 2;
                for (int i = 0; i < 16; i++) begin
                    er[i] = 10'(4 * p + 1 + 2 * i);
                    eq[i] = 10'(4 * p + 1 - 2 * i);
                end
                check_ctl($sformatf("%s.p%0d.add", nm, p), 1'b1, 1'b0, 1'b0);
                check_arr($sformatf("%s.p%0d.addR", nm, p), 0, er);
                check_arr($sformatf("%s.p%0d.addQ", nm, p), 1, eq);
            end else begin
                p = k / 2 - 1;
                check_ctl($sformatf("%s.p%0d.sub", nm, p), 1'b1, 1'b1, (p == 15));
                check_arr($sformatf("%s.p%0d.subR", nm, p), 2, em1);
                check_arr($sformatf("%s.p%0d.subQ", nm, p), 3, em1);
            end
        end
        set_in(1'b0, 1'b0, '0, '0);
        tick();
        if (dout_last === 1'b1) lasts++;
        check_ctl({nm, ".p15.sub"}, 1'b1, 1'b1, 1'b1);
        check_arr({nm, ".p15.subR"}, 2, em1);
        tick();
        check_ctl({nm, ".end_idle"}, 1'b0, 1'b0, 1'b0);
        check_int({nm, ".last_pulses"}, lasts, 1);
    endtask

    initial begin
        blk_t r;
        blk_t q;
        res_t er;
        res_t eq;
        res_t em1;

        n_checks = 0;
        n_errors = 0;

        // ---------------- vector table ----------------
        for (int i = 0; i < 16; i++) begin
            // A=i, B: R=2i, Q=-i
            vecs[0].a_r[i] = 9'(i);        vecs[0].a_q[i] = 9'(i);
            vecs[0].b_r[i] = 9'(2 * i);    vecs[0].b_q[i] = 9'(-i);
            vecs[0].add_r[i] = 10'(3 * i); vecs[0].add_q[i] = 10'(0);
            vecs[0].sub_r[i] = 10'(-i);    vecs[0].sub_q[i] = 10'(2 * i);
            // -256 + -256
            vecs[1].a_r[i] = 9'(-256);     vecs[1].a_q[i] = 9'(-256);
            vecs[1].b_r[i] = 9'(-256);     vecs[1].b_q[i] = 9'(-256);
            vecs[1].add_r[i] = 10'(-512);  vecs[1].add_q[i] = 10'(-512);
            vecs[1].sub_r[i] = 10'(0);     vecs[1].sub_q[i] = 10'(0);
            // 255 and -256
            vecs[2].a_r[i] = 9'(255);      vecs[2].a_q[i] = 9'(255);
            vecs[2].b_r[i] = 9'(-256);     vecs[2].b_q[i] = 9'(-256);
            vecs[2].add_r[i] = 10'(-1);    vecs[2].add_q[i] = 10'(-1);
            vecs[2].sub_r[i] = 10'(511);   vecs[2].sub_q[i] = 10'(511);
            // -256 and 255
            vecs[3].a_r[i] = 9'(-256);     vecs[3].a_q[i] = 9'(-256);
            vecs[3].b_r[i] = 9'(255);      vecs[3].b_q[i] = 9'(255);
            vecs[3].add_r[i] = 10'(-1);    vecs[3].add_q[i] = 10'(-1);
            vecs[3].sub_r[i] = 10'(-511);  vecs[3].sub_q[i] = 10'(-511);
            // mixed per-lane: R A=100-13i, B=7i-50; Q A=-16i, B=15i
            vecs[4].a_r[i] = 9'(100 - 13 * i); vecs[4].a_q[i] = 9'(-16 * i);
            vecs[4].b_r[i] = 9'(7 * i - 50);   vecs[4].b_q[i] = 9'(15 * i);
            vecs[4].add_r[i] = 10'(50 - 6 * i);   vecs[4].add_q[i] = 10'(-i);
            vecs[4].sub_r[i] = 10'(150 - 20 * i); vecs[4].sub_q[i] = 10'(-31 * i);
            em1[i] = 10'(-1);
        end

        // ---------------- reset state ----------------
        rst = 1'b1;
        set_in(1'b0, 1'b0, '0, '0);
        repeat (3) tick();
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check_dp("reset", '0, '0, '0, '0);
        rst = 1'b0;
        tick();

        // ---------------- reset mid-stream ----------------
        set_in(1'b1, 1'b0, vecs[0].a_r, vecs[0].a_q);
        tick();
        set_in(1'b1, 1'b0, vecs[0].b_r, vecs[0].b_q);
        tick();
        check_ctl("pre_rst.add", 1'b1, 1'b0, 1'b0);
        check_arr("pre_rst.addR", 0, vecs[0].add_r);
        // a stray A goes into the buffer, leaving the pair FSM in HALF
        set_in(1'b1, 1'b0, vecs[1].a_r, vecs[1].a_q);
        tick();
        set_in(1'b0, 1'b0, '0, '0);
        #2 rst = 1'b1;
        #1;
        check_ctl("async_rst", 1'b0, 1'b0, 1'b0);
        check_dp("async_rst", '0, '0, '0, '0);
        tick();
        rst = 1'b0;
        tick();
        // a fresh pair after release must pair as A,B (held A was discarded)
        run_vec("post_rst", vecs[2]);

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 5; v++) begin
            run_vec($sformatf("vec%0d", v), vecs[v]);
        end

        // ---------------- continuous stream, frame of 16 pairs ----------------
        stream("stream");

        // ---------------- gap of 5 idle cycles between A and B ----------------
        // held values are from the last stream pair (p=15)
        for (int i = 0; i < 16; i++) begin
            er[i] = 10'(61 + 2 * i);
            eq[i] = 10'(61 - 2 * i);
        end
        set_in(1'b1, 1'b0, vecs[4].a_r, vecs[4].a_q);
        tick();
        for (int g = 0; g < 5; g++) begin
            // junk on the bus with valid low must be ignored
            for (int i = 0; i < 16; i++) begin
                r[i] = 9'(-7 * i);
                q[i] = 9'(3 * g);
            end
            set_in(1'b0, 1'b1, r, q);
            tick();
            check_ctl($sformatf("gap%0d", g), 1'b0, 1'b0, 1'b0);
            check_dp($sformatf("gap%0d.hold", g), er, eq, em1, em1);
        end
        set_in(1'b1, 1'b0, vecs[4].b_r, vecs[4].b_q);
        tick();
        set_in(1'b0, 1'b0, '0, '0);
        check_ctl("gap.add", 1'b1, 1'b0, 1'b0);
        check_dp("gap.add", vecs[4].add_r, vecs[4].add_q, vecs[4].sub_r, vecs[4].sub_q);
        tick();
        check_ctl("gap.sub", 1'b1, 1'b1, 1'b0);
        tick();
        check_ctl("gap.idle", 1'b0, 1'b0, 1'b0);

        // ---------------- sof arriving in HALF realigns the frame ----------------
        for (int i = 0; i < 16; i++) begin
            r[i] = 9'(100);
            q[i] = 9'(-100);
        end
        set_in(1'b1, 1'b0, r, q);
        tick();
        check_bit("orphanA.valid", dout_valid, 1'b0);
        stream("realign");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
